// File: rtl/alu_mc.sv
// Registered execute-stage ALU with a start/done handshake and an iterative shift-add multiply.
// Define ALU_MC_MUL_EN to build the multiplier (opcode 8); otherwise opcode 8 is reserved.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] outHi,
    output logic             jumpFlag
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_XOR  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_RSL  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_LD   = 4'd5;
    localparam logic [3:0] OP_ST   = 4'd6;
    localparam logic [3:0] OP_BLQZ = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    logic [WIDTH-1:0]   sc_out;
    logic               sc_jump;
    logic [2*WIDTH-1:0] rot_full;
    logic [WIDTH-1:0]   dec_a;

    // Rotate by shifting a doubled copy; the upper half is the rotated word.
    assign rot_full = {input1, input1} << input2[SW-1:0];
    assign dec_a    = input1 - WIDTH'(1);

    always_comb begin
        sc_out  = '0;
        sc_jump = 1'b0;
        case (aluOp)
            OP_ADD:  sc_out = input1 + input2;
            OP_XOR:  sc_out = input1 ^ input2;
            OP_AND:  sc_out = input1 & input2;
            OP_RSL:  sc_out = rot_full[2*WIDTH-1:WIDTH];
            OP_MOV:  sc_out = input2;
            OP_LD:   sc_out = input2;
            OP_ST:   sc_out = input1;
            OP_BLQZ: begin
                sc_out  = input2;
                sc_jump = dec_a[WIDTH-1];
            end
            default: begin
                sc_out  = '0;
                sc_jump = 1'b0;
            end
        endcase
    end

`ifdef ALU_MC_MUL_EN
    // state  | meaning
    // S_IDLE | waiting for start; single-cycle ops complete from here
    // S_MUL  | shift-add steps 1..WIDTH-1 in progress (step 0 runs on the accepting edge)
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    state_t           next_state;
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0] step_mc;
    logic [WIDTH-1:0] step_hi_in;
    logic [WIDTH-1:0] step_lo_in;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             mul_go;

    assign mul_go = (state == S_IDLE) && start && (aluOp == OP_MUL);

    // One adder serves every step; in IDLE it runs step 0 on the fresh operands
    // with a cleared accumulator so the product is ready after WIDTH edges.
    assign step_mc    = (state == S_IDLE) ? input1 : mcand;
    assign step_hi_in = (state == S_IDLE) ? '0 : acc_hi;
    assign step_lo_in = (state == S_IDLE) ? input2 : acc_lo;
    assign addend     = step_lo_in[0] ? step_mc : '0;
    assign step_sum   = {1'b0, step_hi_in} + {1'b0, addend};
    assign step_hi    = step_sum[WIDTH:1];
    assign step_lo    = {step_sum[0], step_lo_in[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (mul_go) next_state = S_MUL;
            S_MUL:   if (cnt == '0) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state == S_MUL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            out      <= '0;
            outHi    <= '0;
            jumpFlag <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (mul_go) begin
                    mcand  <= input1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= SW'(WIDTH - 2);
                end else if (start) begin
                    out      <= sc_out;
                    outHi    <= '0;
                    jumpFlag <= sc_jump;
                    done     <= 1'b1;
                end
            end else begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                if (cnt == '0) begin
                    out      <= step_lo;
                    outHi    <= step_hi;
                    jumpFlag <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    cnt <= cnt - SW'(1);
                end
            end
        end
    end
`else
    assign busy  = 1'b0;
    assign outHi = '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            out      <= '0;
            jumpFlag <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                out      <= sc_out;
                jumpFlag <= sc_jump;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): vector table, scoreboard, and multi-cycle sequences.
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] aluOp = 4'd0;
    logic [7:0] input1 = 8'd0;
    logic [7:0] input2 = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic [7:0] outHi;
    logic       jumpFlag;

    int tests = 0;
    int fails = 0;

    alu_mc #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .aluOp(aluOp),
        .input1(input1), .input2(input2), .busy(busy), .done(done),
        .out(out), .outHi(outHi), .jumpFlag(jumpFlag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic [7:0] h;
        logic       j;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eo;
        logic [7:0] eh;
        logic       ej;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest pending expectation.
    always begin
        @(posedge clk);
        #1;
        if (reset_n) begin
            check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_out", {24'd0, out}, {24'd0, e.o});
                    check("sb_outHi", {24'd0, outHi}, {24'd0, e.h});
                    check("sb_jump", {31'd0, jumpFlag}, {31'd0, e.j});
                end
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        check(name, sb.size(), 32'd0);
    endtask

    task automatic issue_single(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] eo, input logic [7:0] eh, input logic ej);
        @(negedge clk);
        start = 1'b1; aluOp = op; input1 = a; input2 = b;
        sb.push_back('{o: eo, h: eh, j: ej});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("single_latency_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int busy_cnt;
        int done_cycle;

        vecs.push_back('{op: 4'd1,  a: 8'hA5, b: 8'h0F, eo: 8'hAA, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd2,  a: 8'hF0, b: 8'h3C, eo: 8'h30, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd3,  a: 8'h81, b: 8'd9,  eo: 8'h03, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd3,  a: 8'h81, b: 8'd0,  eo: 8'h81, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd3,  a: 8'h96, b: 8'd3,  eo: 8'hB4, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd4,  a: 8'h11, b: 8'h22, eo: 8'h22, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd5,  a: 8'h33, b: 8'h44, eo: 8'h44, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd6,  a: 8'h55, b: 8'h66, eo: 8'h55, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd7,  a: 8'h00, b: 8'h3C, eo: 8'h3C, eh: 8'h00, ej: 1'b1});
        vecs.push_back('{op: 4'd7,  a: 8'h05, b: 8'h3C, eo: 8'h3C, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd7,  a: 8'h80, b: 8'h01, eo: 8'h01, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd7,  a: 8'h81, b: 8'h02, eo: 8'h02, eh: 8'h00, ej: 1'b1});
        vecs.push_back('{op: 4'd0,  a: 8'hFF, b: 8'h01, eo: 8'h00, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd15, a: 8'hFF, b: 8'hFF, eo: 8'h00, eh: 8'h00, ej: 1'b0});
        vecs.push_back('{op: 4'd6,  a: 8'h5A, b: 8'h00, eo: 8'h5A, eh: 8'h00, ej: 1'b0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", {24'd0, out}, 32'd0);
        check("rst_outHi", {24'd0, outHi}, 32'd0);
        check("rst_jump", {31'd0, jumpFlag}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ADD wraps, then holds for idle cycles
        issue_single(4'd0, 8'd200, 8'd100, 8'd44, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_out", {24'd0, out}, 32'd44);
            check("hold_done_low", {31'd0, done}, 32'd0);
        end

        // Back-to-back vector table, one op per cycle
        foreach (vecs[i]) begin
            @(negedge clk);
            start = 1'b1; aluOp = vecs[i].op; input1 = vecs[i].a; input2 = vecs[i].b;
            sb.push_back('{o: vecs[i].eo, h: vecs[i].eh, j: vecs[i].ej});
        end
        @(negedge clk);
        start = 1'b0;
        drain("table_drain");

`ifdef ALU_MC_MUL_EN
        // MUL 25 x 13 with an ADD start pulsed while busy
        @(negedge clk);
        start = 1'b1; aluOp = 4'd8; input1 = 8'd25; input2 = 8'd13;
        sb.push_back('{o: 8'h45, h: 8'h01, j: 1'b0});
        busy_cnt = 0;
        done_cycle = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cycle = c;
                break;
            end
            if (busy) busy_cnt++;
            if (c == 1) begin
                start = 1'b0; input1 = 8'hFF; input2 = 8'hFF;
            end
            if (c == 2) begin
                start = 1'b1; aluOp = 4'd0; input1 = 8'd1; input2 = 8'd2;
            end
            if (c == 3) start = 1'b0;
            if (c == 4) check("mul_out_held", {24'd0, out}, 32'h5A);
        end
        check("mul_busy_cycles", busy_cnt, 32'd7);
        check("mul_done_cycle", done_cycle, 32'd8);
        drain("mul1_drain");

        // MUL 255 x 255
        @(negedge clk);
        start = 1'b1; aluOp = 4'd8; input1 = 8'hFF; input2 = 8'hFF;
        sb.push_back('{o: 8'h01, h: 8'hFE, j: 1'b0});
        @(negedge clk);
        start = 1'b0;
        drain("mul2_drain");

        // Reset during MUL aborts without done
        @(negedge clk);
        start = 1'b1; aluOp = 4'd8; input1 = 8'd7; input2 = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midmul_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_out", {24'd0, out}, 32'd0);
        check("abort_outHi", {24'd0, outHi}, 32'd0);
        check("abort_jump", {31'd0, jumpFlag}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("post_abort_idle", {30'd0, busy, done}, 32'd0);
        end
`else
        // Opcode 8 is reserved without the multiplier
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1; aluOp = 4'd8; input1 = 8'd25; input2 = 8'd13;
        sb.push_back('{o: 8'h00, h: 8'h00, j: 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mul_disabled_latency", {31'd0, done}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
        check("mul_disabled_busy", busy_cnt, 32'd0);
        drain("mul_disabled_drain");
`endif

        issue_single(4'd0, 8'd1, 8'd1, 8'd2, 8'd0, 1'b0);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
